// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer.
//
// Oversamples an asynchronous I2S bus (SCLK, LRCK, SDATA) on clk_74b and
// recovers left/right PCM words, MSB-first, DW bits per channel. Each
// completed stereo frame is presented with a one-cycle sample_valid strobe.
// Both 16-bit slots (the LSB arrives on the LRCK-change bit) and longer
// slots (extra bits ignored) are accepted.
//
// Ports:
//   clk_74b      in   system clock, must be >= 4x SCLK
//   reset_n      in   synchronous active-low reset
//   i2s_sclk     in   serial bit clock (async)
//   i2s_lrck     in   word select (async), 0 = left, 1 = right
//   i2s_sdata    in   serial data (async), changes on SCLK falling edge
//   audio_l      out  last complete left word
//   audio_r      out  last complete right word
//   sample_valid out  one-cycle pulse when audio_l/audio_r update
//   locked       out  a good frame has been received since last error/timeout/reset
//   frame_err    out  one-cycle pulse on a short slot
module i2s_rx_deserializer #(
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk_74b,
    input  logic          reset_n,
    input  logic          i2s_sclk,
    input  logic          i2s_lrck,
    input  logic          i2s_sdata,
    output logic [DW-1:0] audio_l,
    output logic [DW-1:0] audio_r,
    output logic          sample_valid,
    output logic          locked,
    output logic          frame_err
);

    localparam int unsigned   IW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
    localparam logic [5:0]    CNT_LAST = 6'(DW - 1);
    localparam logic [5:0]    CNT_DW   = 6'(DW);
    localparam logic [5:0]    CNT_SAT  = 6'h3f;

    typedef enum logic [1:0] {
        StHunt,
        StLeft,
        StRight
    } state_e;

    state_e        state_q;
    logic          sclk_s1, sclk_s2, sclk_s3;
    logic          lrck_s1, lrck_s2;
    logic          sdata_s1, sdata_s2;
    logic          lr_prev;
    logic [5:0]    cnt_q;
    logic [DW-1:0] sh_q;
    logic [DW-1:0] left_hold_q;
    logic [IW-1:0] idle_q;

    logic          sclk_rise;
    logic          boundary;
    logic          timeout;
    logic          complete;
    logic [DW-1:0] sh_shift;
    logic [DW-1:0] word;

    always_comb begin
        sclk_rise = sclk_s2 & ~sclk_s3;
        boundary  = sclk_rise & (lrck_s2 != lr_prev);
        // A concurrent SCLK rise always beats the timeout.
        timeout   = ~sclk_rise & (idle_q == IDLE_MAX);
        complete  = (cnt_q >= CNT_LAST);
        sh_shift  = {sh_q[DW-2:0], sdata_s2};
        // In a slot of exactly DW bits the LSB rides on the LRCK-change bit.
        word      = (cnt_q == CNT_LAST) ? sh_shift : sh_q;
    end

    always_ff @(posedge clk_74b) begin
        if (!reset_n) begin
            state_q      <= StHunt;
            sclk_s1      <= 1'b0;
            sclk_s2      <= 1'b0;
            sclk_s3      <= 1'b0;
            lrck_s1      <= 1'b0;
            lrck_s2      <= 1'b0;
            sdata_s1     <= 1'b0;
            sdata_s2     <= 1'b0;
            lr_prev      <= 1'b0;
            cnt_q        <= '0;
            sh_q         <= '0;
            left_hold_q  <= '0;
            idle_q       <= '0;
            audio_l      <= '0;
            audio_r      <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sclk_s1  <= i2s_sclk;
            sclk_s2  <= sclk_s1;
            sclk_s3  <= sclk_s2;
            lrck_s1  <= i2s_lrck;
            lrck_s2  <= lrck_s1;
            sdata_s1 <= i2s_sdata;
            sdata_s2 <= sdata_s1;

            sample_valid <= 1'b0;
            frame_err    <= 1'b0;

            if (sclk_rise) begin
                idle_q  <= '0;
                lr_prev <= lrck_s2;
            end else if (idle_q != IDLE_MAX) begin
                idle_q <= idle_q + 1'b1;
            end

            if (boundary) begin
                cnt_q <= '0;
                if (cnt_q == CNT_LAST) begin
                    sh_q <= sh_shift;
                end
                unique case (state_q)
                    StHunt: begin
                        // Only a 1->0 edge starts a frame.
                        if (!lrck_s2) begin
                            state_q <= StLeft;
                        end
                    end
                    StLeft: begin
                        if (complete) begin
                            left_hold_q <= word;
                            state_q     <= StRight;
                        end else begin
                            frame_err <= 1'b1;
                            locked    <= 1'b0;
                            state_q   <= StHunt;
                        end
                    end
                    StRight: begin
                        if (complete) begin
                            audio_l      <= left_hold_q;
                            audio_r      <= word;
                            sample_valid <= 1'b1;
                            locked       <= 1'b1;
                        end else begin
                            frame_err   <= 1'b1;
                            locked      <= 1'b0;
                            left_hold_q <= '0;
                        end
                        // The 1->0 edge that closes the right slot opens a left one.
                        state_q <= StLeft;
                    end
                    default: state_q <= StHunt;
                endcase
            end else if (sclk_rise) begin
                if (cnt_q < CNT_DW) begin
                    sh_q <= sh_shift;
                end
                if (cnt_q != CNT_SAT) begin
                    cnt_q <= cnt_q + 6'd1;
                end
            end else if (timeout) begin
                state_q <= StHunt;
                locked  <= 1'b0;
                cnt_q   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: drives an I2S bus at clk/24 and
// checks recovered words, strobes, lock and error behaviour.
module tb_i2s_rx_deserializer;

    localparam int unsigned DW      = 16;
    localparam int unsigned TIMEOUT = 1024;
    localparam int          HALF    = 12;

    logic          clk_74b = 1'b0;
    logic          reset_n;
    logic          i2s_sclk;
    logic          i2s_lrck;
    logic          i2s_sdata;
    logic [DW-1:0] audio_l;
    logic [DW-1:0] audio_r;
    logic          sample_valid;
    logic          locked;
    logic          frame_err;

    int            checks = 0;
    int            errors = 0;
    int            valid_hi = 0;
    int            err_hi = 0;
    logic [DW-1:0] cap_l = '0;
    logic [DW-1:0] cap_r = '0;
    logic          tail = 1'b0;

    i2s_rx_deserializer #(
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_74b      (clk_74b),
        .reset_n      (reset_n),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sdata    (i2s_sdata),
        .audio_l      (audio_l),
        .audio_r      (audio_r),
        .sample_valid (sample_valid),
        .locked       (locked),
        .frame_err    (frame_err)
    );

    always #5 clk_74b = ~clk_74b;

    // Count strobe high-cycles and latch the words presented with each strobe.
    always @(negedge clk_74b) begin
        if (sample_valid === 1'b1) begin
            valid_hi <= valid_hi + 1;
            cap_l    <= audio_l;
            cap_r    <= audio_r;
        end
        if (frame_err === 1'b1) begin
            err_hi <= err_hi + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One I2S slot of 'slot' bit periods. Period 0 carries the previous
    // slot's trailing bit; the word follows MSB-first, zero padded.
    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int slot);
        logic b;
        for (int p = 0; p < slot; p++) begin
            if (p == 0) b = tail;
            else        b = (p - 1 < int'(DW)) ? w[int'(DW) - p] : 1'b0;
            i2s_sclk  = 1'b0;
            i2s_lrck  = lr;
            i2s_sdata = b;
            repeat (HALF) @(negedge clk_74b);
            i2s_sclk = 1'b1;
            repeat (HALF) @(negedge clk_74b);
        end
        tail = (slot - 1 < int'(DW)) ? w[int'(DW) - slot] : 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk_74b);
        reset_n = 1'b0;
        @(negedge clk_74b);
        check("rst_audio_l", 32'(audio_l), 32'h0);
        check("rst_audio_r", 32'(audio_r), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        i2s_sclk  = 1'b0;
        i2s_lrck  = 1'b0;
        i2s_sdata = 1'b0;
        repeat (4) @(negedge clk_74b);
        check("init_audio_l", 32'(audio_l), 32'h0);
        check("init_audio_r", 32'(audio_r), 32'h0);
        check("init_valid", 32'(sample_valid), 32'h0);
        check("init_locked", 32'(locked), 32'h0);
        check("init_frame_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        @(negedge clk_74b);

        // Nominal 32-bit slots from HUNT.
        send_slot(1'b1, 16'h0000, 32);
        send_slot(1'b0, 16'hA5C3, 32);
        send_slot(1'b1, 16'h0F81, 32);
        check("t1_locked_pre", 32'(locked), 32'h0);
        send_slot(1'b0, 16'h1234, 32);
        check("t1_valid_cnt", 32'(valid_hi), 32'd1);
        check("t1_cap_l", 32'(cap_l), 32'hA5C3);
        check("t1_cap_r", 32'(cap_r), 32'h0F81);
        check("t1_locked", 32'(locked), 32'h1);
        send_slot(1'b1, 16'hFEDC, 32);
        send_slot(1'b0, 16'h5A5A, 32);
        check("t1_valid_cnt2", 32'(valid_hi), 32'd2);
        check("t1_audio_l2", 32'(audio_l), 32'h1234);
        check("t1_audio_r2", 32'(audio_r), 32'hFEDC);

        // 16-bit slots: LSB arrives on the LRCK-change bit.
        send_slot(1'b1, 16'h3C3C, 16);
        send_slot(1'b0, 16'h8001, 16);
        send_slot(1'b1, 16'h7FFE, 16);
        send_slot(1'b0, 16'h0000, 16);
        check("t2_valid_cnt", 32'(valid_hi), 32'd4);
        check("t2_cap_l", 32'(cap_l), 32'h8001);
        check("t2_cap_r", 32'(cap_r), 32'h7FFE);

        // Truncated left slot (10 bits).
        send_slot(1'b1, 16'h1111, 16);
        check("t4_locked_before", 32'(locked), 32'h1);
        send_slot(1'b0, 16'hFFFF, 10);
        send_slot(1'b1, 16'h0000, 32);
        check("t4_err_cnt", 32'(err_hi), 32'd1);
        check("t4_locked", 32'(locked), 32'h0);
        check("t4_valid_cnt", 32'(valid_hi), 32'd5);
        send_slot(1'b0, 16'hC0DE, 32);
        send_slot(1'b1, 16'hBEEF, 32);
        send_slot(1'b0, 16'h0000, 32);
        check("t4_recover_cnt", 32'(valid_hi), 32'd6);
        check("t4_recover_l", 32'(cap_l), 32'hC0DE);
        check("t4_recover_r", 32'(cap_r), 32'hBEEF);
        check("t4_recover_locked", 32'(locked), 32'h1);

        // SCLK stopped: lock drops about TIMEOUT cycles after the last rise.
        repeat (TIMEOUT - 40) @(negedge clk_74b);
        check("t5_locked_early", 32'(locked), 32'h1);
        repeat (50) @(negedge clk_74b);
        check("t5_locked_late", 32'(locked), 32'h0);
        check("t5_audio_l", 32'(audio_l), 32'hC0DE);
        check("t5_audio_r", 32'(audio_r), 32'hBEEF);
        check("t5_err_cnt", 32'(err_hi), 32'd1);
        send_slot(1'b1, 16'h0000, 32);
        send_slot(1'b0, 16'h1357, 32);
        send_slot(1'b1, 16'h2468, 32);
        send_slot(1'b0, 16'h0000, 32);
        check("t5_restart_cnt", 32'(valid_hi), 32'd7);
        check("t5_restart_l", 32'(cap_l), 32'h1357);
        check("t5_restart_r", 32'(cap_r), 32'h2468);
        check("t5_restart_locked", 32'(locked), 32'h1);

        // Reset mid-left-word; the interrupted frame is lost.
        send_slot(1'b1, 16'h4242, 32);
        send_slot(1'b0, 16'hFFFF, 8);
        check("t6_pre_cnt", 32'(valid_hi), 32'd8);
        pulse_reset();
        send_slot(1'b0, 16'h0000, 24);
        send_slot(1'b1, 16'h7777, 32);
        check("t6_lost_cnt", 32'(valid_hi), 32'd8);
        send_slot(1'b0, 16'h6B2D, 32);
        send_slot(1'b1, 16'hD4E1, 32);
        send_slot(1'b0, 16'h0000, 32);
        check("t6_cnt", 32'(valid_hi), 32'd9);
        check("t6_cap_l", 32'(cap_l), 32'h6B2D);
        check("t6_cap_r", 32'(cap_r), 32'hD4E1);

        // Start mid-right-channel after reset.
        pulse_reset();
        send_slot(1'b1, 16'h9999, 12);
        send_slot(1'b0, 16'h0246, 32);
        check("t3_partial_cnt", 32'(valid_hi), 32'd9);
        send_slot(1'b1, 16'h8ACE, 32);
        send_slot(1'b0, 16'h0000, 32);
        check("t3_cnt", 32'(valid_hi), 32'd10);
        check("t3_cap_l", 32'(cap_l), 32'h0246);
        check("t3_cap_r", 32'(cap_r), 32'h8ACE);
        check("t3_err_cnt", 32'(err_hi), 32'd1);
        check("t3_locked", 32'(locked), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_deserializer.md
Name: i2s_rx_deserializer

Overview:
- Receive-side counterpart of the core's I2S output path.
- Oversamples an external I2S bus (SCLK, LRCK, SDATA) on one fast system clock and recovers left/right PCM words.
- Presents each completed stereo frame as a one-cycle valid strobe.
- Used for loopback verification of the audio output chain and for capturing external I2S sources into the core clock domain.

Parameters:
- DW, 16, PCM word width captured per channel (MSB-first); 2..32.
- TIMEOUT, 1024, clk_74b cycles without an SCLK rising edge before the receiver drops lock.

Ports:
- clk_74b  input  1  system clock; all logic on its rising edge; must be ≥4× SCLK frequency.
- reset_n  input  1  synchronous, active-low reset.
- i2s_sclk  input  1  serial bit clock, asynchronous to clk_74b.
- i2s_lrck  input  1  word select, asynchronous; 0 = left, 1 = right.
- i2s_sdata  input  1  serial data, asynchronous; changes on SCLK falling edge.
- audio_l  output  DW  last complete left word.
- audio_r  output  DW  last complete right word.
- sample_valid  output  1  one-cycle pulse when audio_l/audio_r update.
- locked  output  1  at least one good frame received since last error/timeout/reset.
- frame_err  output  1  one-cycle pulse on short slot.

Behaviour:
Reset:
- All outputs 0. State HUNT. Counters 0. Synchronizer flops 0.

Input sampling:
- Each input passes through 2-flop synchronizer (s1, s2).
- SCLK has a third flop s3.
- sclk_rise = s2_sclk & ~s3_sclk.
- On a sclk_rise cycle, LRCK and SDATA are taken from their s2 flops.
- lr_prev holds LRCK as of the previous sclk_rise.
- boundary = sclk_rise & (lrck != lr_prev).

Bit counter `cnt` (6 bits, saturates at 63) and shift register `sh` (DW bits):
- On boundary:
  - Evaluate completion for the slot just ended: complete = (cnt ≥ DW-1).
  - If cnt == DW-1, shift the boundary SDATA bit in as the final LSB (16-bit-slot case). Otherwise the boundary bit is the previous slot's trailing bit and is ignored.
  - Then cnt←0.
- On a non-boundary sclk_rise: if cnt < DW, sh←{sh[DW-2:0], sdata}. cnt←sat(cnt+1).
- 32-bit slot: cnt reaches 31 at the next boundary. 16-bit slot: cnt reaches 15.

State machine (transitions only on boundary or timeout):
- HUNT
  - Boundary with LRCK 1→0 → LEFT.
  - Other boundaries ignored.
  - No outputs change.
- LEFT, boundary (0→1):
  - complete: left_hold←word, → RIGHT.
  - else: frame_err pulse, locked←0, → HUNT.
- RIGHT, boundary (1→0):
  - complete: audio_l←left_hold, audio_r←word, sample_valid pulse, locked←1, → LEFT.
  - else: frame_err pulse, locked←0, left_hold discarded, → LEFT. A 1→0 edge is a valid left start.

Timeout:
- Idle counter clears on every sclk_rise and increments otherwise.
- At TIMEOUT-1: → HUNT, locked←0, cnt←0.
- No frame_err on timeout.
- audio_l/audio_r hold their last values.

Timing:
- A SCLK rise first captured by s1 on clk_74b edge k causes state/output update on edge k+2.
- sample_valid is high for exactly one clk_74b cycle per frame.
- audio_l/audio_r are stable from that cycle until the next sample_valid.

Other rules:
- Data bits beyond DW in a slot are ignored.
- SDATA is not interpreted as signed; words are passed through raw.
- reset_n low mid-frame: all state cleared on that edge. The first frame after release is lost (HUNT waits for the next 1→0).
- Simultaneous timeout and sclk_rise: the sclk_rise wins; the idle counter clears.

Test Plan:
- Nominal 32-bit slot, SCLK = clk/24: frames L=16'hA5C3, R=16'h0F81 → after 1 frame from HUNT, sample_valid pulse, audio_l=A5C3, audio_r=0F81, locked=1; exactly one pulse per subsequent frame.
- 16-bit slot (SCLK=32Fs), L=16'h8001, R=16'h7FFE → boundary-bit LSB capture correct: audio_l=8001, audio_r=7FFE.
- Start mid-right-channel: first complete frame after first LRCK 1→0 is the only output; no sample_valid for the partial frame; frame_err stays 0.
- Truncated left slot (LRCK toggles after 10 bits) → frame_err one pulse, locked=0, no sample_valid; next full frame recovers with locked=1.
- Stop SCLK for TIMEOUT+10 cycles → locked falls at cycle TIMEOUT after the last rise, audio_l/audio_r retain values, frame_err=0; restart resumes after one full frame.
- Assert reset_n=0 for 1 cycle mid-left-word → all outputs 0 next cycle; next valid frame captured correctly.
